// File: rtl/security_decrypt.sv
// Receive-side decryptor: inverts enc = (((x-3)^2)+9)*3 one step per cycle,
// gated by a 16-bit access key with sticky lockout after repeated bad keys.
module security_decrypt #(
    parameter logic [15:0] KEY       = 16'h0032,
    parameter int          MAX_FAILS = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] data_in_i,
    input  logic        encryption_on_i,
    input  logic [15:0] key_in_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] data_out_o,
    output logic        key_err_o,
    output logic        locked_o
);

    localparam int          FW       = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
    localparam logic [31:0] INV3     = 32'hAAAAAAAB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_SUB,
        S_XOR,
        S_ADD,
        S_OUT
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    r_q, r_d;
    logic [31:0]    data_out_q, data_out_d;
    logic           out_valid_q, out_valid_d;
    logic           key_err_q, key_err_d;
    logic [FW-1:0]  fail_cnt_q, fail_cnt_d;
    logic           locked_q, locked_d;
    logic           accept;

    assign in_ready_o  = (state_q == S_IDLE) && !locked_q;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = out_valid_q;
    assign data_out_o  = data_out_q;
    assign key_err_o   = key_err_q;
    assign locked_o    = locked_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            fail_cnt_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            key_err_q   <= key_err_d;
            fail_cnt_q  <= fail_cnt_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        key_err_d   = 1'b0;
        fail_cnt_d  = fail_cnt_q;
        locked_d    = locked_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (key_in_i == KEY) begin
                        r_d        = data_in_i;
                        fail_cnt_d = '0;
                        if (encryption_on_i) begin
                            state_d = S_MUL;
                        end else begin
                            data_out_d  = data_in_i;
                            out_valid_d = 1'b1;
                            state_d     = S_OUT;
                        end
                    end else begin
                        key_err_d = 1'b1;
                        if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + FW'(1);
                        if (fail_cnt_q + FW'(1) == FAIL_MAX) locked_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                r_d     = r_q * INV3;
                state_d = S_SUB;
            end
            S_SUB: begin
                r_d     = r_q - 32'd9;
                state_d = S_XOR;
            end
            S_XOR: begin
                r_d     = r_q ^ 32'h2;
                state_d = S_ADD;
            end
            S_ADD: begin
                data_out_d  = r_q + 32'd3;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
